// File: rtl/huff_bit_packer.sv
// huff_bit_packer: packs variable-length Huffman codes (0..10 bits, MSB first)
// into bytes through a 17-bit left-aligned accumulator, with a flush that
// pads the final partial byte with zeros.
//
// Optional build macro: HUFF_PACK_BYTE_COUNT_EN
//   defined   -> byte_count counts every output byte (wraps at 16 bits)
//   undefined -> byte_count is tied to 0 and no counter register exists
//
// state | meaning
// ------+---------------------------------------------------------------
// PACK  | accept symbols while fewer than 8 bits are buffered, emit full bytes
// FLUSH | no input; drain full bytes, then one zero-padded byte, then pulse
//       | flush_done and return to PACK
module huff_bit_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  code_in,
  input  logic [3:0]  len_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        flush_done,
  output logic [4:0]  fill_level,
  output logic [15:0] byte_count
);

  typedef enum logic {PACK = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state;
  logic [16:0] acc;
  logic [4:0]  fill;

  logic        in_xfer;
  logic        out_xfer;
  logic [3:0]  len_eff;
  logic [16:0] len_mask;
  logic [16:0] code_field;
  logic [4:0]  append_shamt;
  logic [16:0] acc_appended;

  // Handshake signals decode directly from the registered state and fill, so
  // in_ready and out_valid can never be high together (fill <= 7 vs >= 8).
  assign in_ready   = (state == PACK) && (fill <= 5'd7);
  assign out_valid  = (state == PACK) ? (fill >= 5'd8) : (fill != 5'd0);
  assign flush_done = (state == FLUSH) && (fill == 5'd0);
  assign out_byte   = acc[16:9];
  assign fill_level = fill;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Clamp the length, isolate the valid code bits and place them directly
  // below the bits already buffered. Only used when fill <= 7, so the shift
  // amount 17 - fill - len never goes negative.
  always_comb begin
    len_eff      = (len_in > 4'd10) ? 4'd10 : len_in;
    len_mask     = (17'd1 << len_eff) - 17'd1;
    code_field   = {7'd0, code_in} & len_mask;
    append_shamt = 5'd17 - fill - {1'b0, len_eff};
    acc_appended = acc | (code_field << append_shamt);
  end

  // Main FSM: accumulator, fill level and PACK/FLUSH sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PACK;
      acc   <= '0;
      fill  <= '0;
    end else begin
      case (state)
        PACK: begin
          if (in_xfer) begin
            acc  <= acc_appended;
            fill <= fill + {1'b0, len_eff};
          end else if (out_xfer) begin
            acc  <= {acc[8:0], 8'd0};
            fill <= fill - 5'd8;
          end
          if (flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fill == 5'd0) begin
            state <= PACK;
          end else if (out_xfer) begin
            if (fill >= 5'd8) begin
              acc  <= {acc[8:0], 8'd0};
              fill <= fill - 5'd8;
            end else begin
              // Partial byte already zero-padded: bits below fill are always 0.
              acc  <= '0;
              fill <= '0;
            end
          end
        end
        default: begin
          state <= PACK;
        end
      endcase
    end
  end

`ifdef HUFF_PACK_BYTE_COUNT_EN
  logic [15:0] byte_cnt_q;

  // Count every byte handed downstream, padded flush bytes included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= '0;
    end else if (out_xfer) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign byte_count = byte_cnt_q;
`else
  assign byte_count = 16'd0;
`endif

endmodule

// File: doc/huff_bit_packer.md
HUFF_BIT_PACKER -- requirements
Module: huff_bit_packer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-003 code_in  input  10  Huffman code; valid bits are code_in[len_in-1:0], MSB of that field transmitted first.
REQ-004 len_in  input  4  code length in bits; legal range 0..10.
REQ-005 in_valid  input  1  code_in/len_in valid this cycle.
REQ-006 in_ready  output  1  packer accepts a symbol this cycle; a transfer occurs when in_valid && in_ready.
REQ-007 flush  input  1  request to emit all buffered bits, padding the final partial byte.
REQ-008 out_byte  output  8  packed byte; the first-received bit is in out_byte[7].
REQ-009 out_valid  output  1  out_byte valid.
REQ-010 out_ready  input  1  downstream consumes out_byte when out_valid && out_ready.
REQ-011 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-012 fill_level  output  5  number of buffered bits, 0..17.
REQ-013 byte_count  output  16  count of bytes transferred on the output (see Configuration).

Function
REQ-014 The block SHALL contain a 17-bit left-aligned accumulator; the oldest bit sits at bit 16 and out_byte equals accumulator[16:9].
REQ-015 The block SHALL implement the states PACK and FLUSH.
REQ-016 In PACK: in_ready = 1 iff fill_level <= 7; out_valid = 1 iff fill_level >= 8.
REQ-017 On an input transfer, the block SHALL append the len_in bits directly after the existing bits and add len_in to fill_level, all in the same edge.
REQ-018 len_in = 0 SHALL be accepted with no change to the accumulator or fill_level.
REQ-019 len_in > 10 SHALL be treated as 10.
REQ-020 On an output transfer, the block SHALL shift the accumulator left by 8, zero-fill, and subtract 8 from fill_level.
REQ-021 Input and output transfers are mutually exclusive by construction; in_ready and out_valid are never both 1.
REQ-022 out_byte SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-023 PACK -> FLUSH transition: flush sampled 1 in PACK; if an input transfer occurs on the same edge, the symbol is appended first.
REQ-024 In FLUSH, in_ready SHALL be 0 and flush is ignored.
REQ-025 In FLUSH, full bytes are emitted per REQ-020.
REQ-026 In FLUSH with 1 <= fill_level <= 7: out_valid = 1 and out_byte = remaining bits padded with 0 in the LSBs; on transfer, fill_level becomes 0.
REQ-027 In FLUSH with fill_level = 0: flush_done = 1 for exactly one cycle and the block returns to PACK on the same edge.
REQ-028 A flush with an empty buffer SHALL produce no byte and pulse flush_done on the cycle after entering FLUSH.
REQ-029 Output latency: out_valid SHALL assert on the cycle after the input transfer that brings fill_level to >= 8.

Reset
REQ-030 While reset = 1: state = PACK, accumulator = 0, fill_level = 0, out_valid = 0, flush_done = 0, byte_count = 0, out_byte = 0.
REQ-031 in_ready SHALL be 1 from the first edge after reset deasserts.
REQ-032 Reset asserted mid-FLUSH or mid-byte SHALL discard all buffered bits immediately, with no padded byte and no flush_done.

Configuration
REQ-033 Macro HUFF_PACK_BYTE_COUNT_EN defined: byte_count increments by 1 on every output transfer, including padded bytes, and wraps from 65535 to 0.
REQ-034 Macro HUFF_PACK_BYTE_COUNT_EN undefined: byte_count is constant 0 and no counter register is synthesised; all other behaviour is identical.

Verification
REQ-035 Eight symbols code_in = 10'h001, len_in = 1, with out_ready = 1 -> one byte 0xFF; fill_level returns to 0.
REQ-036 code_in = 10'b1010101011, len_in = 10, then flush -> bytes 0xAA then 0xC0, flush_done pulses once, state returns to PACK.
REQ-037 Buffer holding >= 8 bits with out_ready = 0 for 5 cycles -> out_byte stable, out_valid = 1, in_ready = 0 throughout; out_ready = 1 -> byte transferred.
REQ-038 len_in = 0 and len_in = 12 with code_in = 10'h3FF -> the first leaves fill_level unchanged, the second adds 10 bits.
REQ-039 Flush on empty buffer -> no out_valid, flush_done one cycle later; reset during FLUSH with 3 bits buffered -> no byte emitted, fill_level = 0.
REQ-040 With HUFF_PACK_BYTE_COUNT_EN defined, 65537 bytes transferred -> byte_count = 1; with the macro undefined -> byte_count = 0 throughout.
